exception_irq_ctrl: RTL
=======================

Name: exception_irq_ctrl

Overview:
Parametrised exception and interrupt controller for the 5-stage MIPS pipeline. It replaces the single-level overflow/undef/NMI handler with:
- a prioritised set of maskable IRQ lines, with per-line pending latches and acknowledge;
- a two-state handler FSM with ERET return and double-fault detection;
- a programmable vector table.

It drives the pipeline flushes, the PC redirect mux select/address, the EPC and the cause code.

Parameters:
- NUM_IRQ, 4, number of maskable interrupt lines (1..8).
- ADDR_WIDTH, 32, PC/EPC/vector width.
- VEC_BASE, 32'h0000_0080, base address of the vector table.
- VEC_STRIDE, 32'h0000_0010, spacing between vector entries.

Ports:
- clk  in  1  system clock, all state on rising edge
- reset  in  1  synchronous, active-high
- ovf_ex  in  1  arithmetic overflow flagged by instruction in EX
- pc_ex  in  ADDR_WIDTH  PC+4 of instruction in EX
- undef_id  in  1  undefined opcode decoded in ID
- pc_id  in  ADDR_WIDTH  PC+4 of instruction in ID
- eret_id  in  1  ERET decoded in ID
- irq  in  NUM_IRQ  level interrupt requests
- mask_wr  in  1  write enable for IRQ mask
- mask_din  in  NUM_IRQ  new mask value (1 = enabled)
- irq_ack  out  NUM_IRQ  one-hot, 1-cycle pulse when IRQ i is taken
- ex_mem_flush, id_ex_flush, if_id_flush  out  1 each  pipeline register flushes
- choose_epc  out  1  PC mux select: take redirect_addr
- redirect_addr  out  ADDR_WIDTH  vector address or EPC on return
- epc  out  ADDR_WIDTH  saved restart address (registered)
- cause  out  4  registered cause code
- in_handler  out  1  FSM is in HANDLER

Behaviour:
- Reset (synchronous): state=IDLE, epc=0, cause=0, mask=0 (all IRQs disabled), pending=0. All flushes, choose_epc, irq_ack and redirect_addr are 0 while reset is high.
- Pending: pend[i] is set each cycle irq[i]=1, and cleared on the cycle its ack fires. The clear wins over a set in that same cycle. An IRQ is eligible when pend[i] & mask[i].
- mask_wr updates the mask at the next edge. A write in the same cycle as a take does not affect that take.
- Event selection is combinational in the current cycle and committed at the next edge. Flushes, choose_epc and redirect_addr are asserted in the same cycle as the event.
- Priority in IDLE: ovf_ex > undef_id > eligible IRQ (lowest index wins). Only one event is taken per cycle.
- Overflow:
  - Flush EX/MEM, ID/EX and IF/ID.
  - epc <= pc_ex-4; cause <= 4'd2; redirect = VEC_BASE.
- Undef:
  - Flush ID/EX and IF/ID only.
  - epc <= pc_id, so the faulting instruction is skipped.
  - cause <= 4'd1; redirect = VEC_BASE+VEC_STRIDE.
- IRQ i:
  - Flush all three pipeline registers.
  - epc <= pc_ex-4; cause <= 8+i; redirect = VEC_BASE+(3+i)*VEC_STRIDE; irq_ack[i]=1.
- Every take: state <= HANDLER.
- HANDLER:
  - IRQs are blocked; pending bits keep accumulating.
  - ovf_ex or undef_id is a double fault: flush all, cause <= 4'd3, epc unchanged, redirect = VEC_BASE+2*VEC_STRIDE, stay in HANDLER.
  - eret_id: flush IF/ID only, choose_epc=1, redirect_addr=epc, state <= IDLE, cause <= 0.
  - A fault in the same cycle as eret_id wins: double fault, no return.
- eret_id in IDLE is ignored: no flush, no redirect.
- Arithmetic: all address sums are modulo 2^ADDR_WIDTH. pc_ex-4 wraps (pc_ex=0 gives all-ones minus 3).
- Vector offsets use (k*VEC_STRIDE) truncated to ADDR_WIDTH.
- Reset asserted in HANDLER returns to IDLE immediately and discards pending IRQs.

Optional Feature:
- Macro: EXC_IRQ_CTRL_NMI_EN.
- Enabled:
  - Adds input nmi (1).
  - Rising edge (registered previous value) sets nmi_pend, which has highest priority in both IDLE and HANDLER.
  - Take: flush all; epc <= pc_ex-4, overwriting epc even in HANDLER (non-recoverable by design); cause <= 4'd4; redirect = VEC_BASE+(3+NUM_IRQ)*VEC_STRIDE; state <= HANDLER; nmi_pend cleared.
- Disabled: no nmi port, cause 4 is never produced, and logic is otherwise identical.

Test Plan:
- Reset, mask_wr=1 with mask_din=4'b1111, pc_ex=0x100, ovf_ex=1 for 1 cycle -> same cycle: all flushes=1, choose_epc=1, redirect_addr=0x80. Next cycle: epc=0xFC, cause=2, in_handler=1.
- IDLE, undef_id=1, pc_id=0x204 -> ID/EX and IF/ID flush=1, EX/MEM flush=0, redirect=0x90. Then epc=0x204, cause=1.
- Mask=4'b1111, irq=4'b0110 for 1 cycle, pc_ex=0x40 -> irq_ack=4'b0010, redirect=0xC0, epc=0x3C, cause=9. After ERET (redirect=0x3C, in_handler=0), IRQ2 is taken next: ack=4'b0100, redirect=0xD0.
- In HANDLER with epc=0xFC, ovf_ex=1 together with eret_id=1 -> redirect=0xA0, cause=3, epc stays 0xFC, in_handler stays 1.
- Mask=0, irq=4'b0001 held -> no ack. Then mask_wr with 4'b0001 -> take on the following cycle, redirect=0xB0.
- Same cycle: ovf_ex=1, undef_id=1, irq[0] eligible -> overflow taken (cause=2), irq pend[0] retained, undef dropped (ID/EX flushed).

Source files
------------

// File: rtl/exception_irq_ctrl.sv
// Prioritised exception/interrupt controller for the 5-stage MIPS pipeline.
// Optional NMI input is enabled by defining EXC_IRQ_CTRL_NMI_EN.
module exception_irq_ctrl #(
  parameter int unsigned           NUM_IRQ    = 4,
  parameter int unsigned           ADDR_WIDTH = 32,
  parameter logic [ADDR_WIDTH-1:0] VEC_BASE   = ADDR_WIDTH'(32'h0000_0080),
  parameter logic [ADDR_WIDTH-1:0] VEC_STRIDE = ADDR_WIDTH'(32'h0000_0010)
) (
  input  logic                  clk,
  input  logic                  reset,
`ifdef EXC_IRQ_CTRL_NMI_EN
  input  logic                  nmi,
`endif
  input  logic                  ovf_ex,
  input  logic [ADDR_WIDTH-1:0] pc_ex,
  input  logic                  undef_id,
  input  logic [ADDR_WIDTH-1:0] pc_id,
  input  logic                  eret_id,
  input  logic [NUM_IRQ-1:0]    irq,
  input  logic                  mask_wr,
  input  logic [NUM_IRQ-1:0]    mask_din,
  output logic [NUM_IRQ-1:0]    irq_ack,
  output logic                  ex_mem_flush,
  output logic                  id_ex_flush,
  output logic                  if_id_flush,
  output logic                  choose_epc,
  output logic [ADDR_WIDTH-1:0] redirect_addr,
  output logic [ADDR_WIDTH-1:0] epc,
  output logic [3:0]            cause,
  output logic                  in_handler
);

  localparam logic [0:0] ST_IDLE    = 1'b0;
  localparam logic [0:0] ST_HANDLER = 1'b1;
  localparam logic [ADDR_WIDTH-1:0] PC_STEP = ADDR_WIDTH'(32'd4);

  logic [0:0]            state_q, state_d;
  logic [ADDR_WIDTH-1:0] epc_q, epc_d;
  logic [3:0]            cause_q, cause_d;
  logic [NUM_IRQ-1:0]    mask_q, mask_d;
  logic [NUM_IRQ-1:0]    pend_q, pend_d;
  logic [NUM_IRQ-1:0]    elig_s, ack_s;
  logic [2:0]            irq_sel_s;
  logic                  irq_hit_s;
  logic [2:0]            flush_s;
  logic                  choose_s;
  logic [ADDR_WIDTH-1:0] redirect_s;

  function automatic logic [ADDR_WIDTH-1:0] vec_addr(input logic [ADDR_WIDTH-1:0] k);
    return VEC_BASE + k * VEC_STRIDE;
  endfunction

`ifdef EXC_IRQ_CTRL_NMI_EN
  logic nmi_q, nmi_pend_q, nmi_pend_d, nmi_take_s;
  assign nmi_pend_d = (nmi_pend_q | (nmi & ~nmi_q)) & ~nmi_take_s;
`endif

  assign elig_s    = pend_q & mask_q;
  assign irq_hit_s = |elig_s;
  // A pending bit being acknowledged this cycle is cleared even if the line is still high.
  assign pend_d    = (pend_q | irq) & ~ack_s;
  assign mask_d    = mask_wr ? mask_din : mask_q;

  always_comb begin
    irq_sel_s = 3'd0;
    for (int i = int'(NUM_IRQ) - 1; i >= 0; i--) begin
      irq_sel_s = elig_s[i] ? 3'(i) : irq_sel_s;
    end
  end

  always_comb begin
    state_d    = state_q;
    epc_d      = epc_q;
    cause_d    = cause_q;
    flush_s    = 3'b000;
    choose_s   = 1'b0;
    redirect_s = '0;
    ack_s      = '0;
`ifdef EXC_IRQ_CTRL_NMI_EN
    nmi_take_s = 1'b0;
`endif
    if (reset) begin
      flush_s = 3'b000;
    end else begin
`ifdef EXC_IRQ_CTRL_NMI_EN
      if (nmi_pend_q) begin
        nmi_take_s = 1'b1;
        flush_s    = 3'b111;
        choose_s   = 1'b1;
        redirect_s = vec_addr(ADDR_WIDTH'(NUM_IRQ + 32'd3));
        epc_d      = pc_ex - PC_STEP;
        cause_d    = 4'd4;
        state_d    = ST_HANDLER;
      end else
`endif
      if (state_q == ST_IDLE) begin
        if (ovf_ex) begin
          flush_s    = 3'b111;
          choose_s   = 1'b1;
          redirect_s = VEC_BASE;
          epc_d      = pc_ex - PC_STEP;
          cause_d    = 4'd2;
          state_d    = ST_HANDLER;
        end else if (undef_id) begin
          flush_s    = 3'b011;
          choose_s   = 1'b1;
          redirect_s = vec_addr(ADDR_WIDTH'(4'd1));
          epc_d      = pc_id;
          cause_d    = 4'd1;
          state_d    = ST_HANDLER;
        end else if (irq_hit_s) begin
          flush_s    = 3'b111;
          choose_s   = 1'b1;
          redirect_s = vec_addr(ADDR_WIDTH'(4'd3) + ADDR_WIDTH'(irq_sel_s));
          epc_d      = pc_ex - PC_STEP;
          cause_d    = {1'b1, irq_sel_s};
          state_d    = ST_HANDLER;
          for (int i = 0; i < int'(NUM_IRQ); i++) begin
            ack_s[i] = (irq_sel_s == 3'(i));
          end
        end else begin
          state_d = ST_IDLE;
        end
      end else begin
        // A fault inside the handler beats a simultaneous ERET; epc is kept.
        if (ovf_ex || undef_id) begin
          flush_s    = 3'b111;
          choose_s   = 1'b1;
          redirect_s = vec_addr(ADDR_WIDTH'(4'd2));
          cause_d    = 4'd3;
        end else if (eret_id) begin
          flush_s    = 3'b001;
          choose_s   = 1'b1;
          redirect_s = epc_q;
          cause_d    = 4'd0;
          state_d    = ST_IDLE;
        end else begin
          state_d = ST_HANDLER;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_IDLE;
      epc_q   <= '0;
      cause_q <= 4'd0;
      mask_q  <= '0;
      pend_q  <= '0;
`ifdef EXC_IRQ_CTRL_NMI_EN
      nmi_q      <= 1'b0;
      nmi_pend_q <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      epc_q   <= epc_d;
      cause_q <= cause_d;
      mask_q  <= mask_d;
      pend_q  <= pend_d;
`ifdef EXC_IRQ_CTRL_NMI_EN
      nmi_q      <= nmi;
      nmi_pend_q <= nmi_pend_d;
`endif
    end
  end

  assign ex_mem_flush  = flush_s[2];
  assign id_ex_flush   = flush_s[1];
  assign if_id_flush   = flush_s[0];
  assign choose_epc    = choose_s;
  assign redirect_addr = redirect_s;
  assign irq_ack       = ack_s;
  assign epc           = epc_q;
  assign cause         = cause_q;
  assign in_handler    = (state_q == ST_HANDLER);

endmodule
